// File: rtl/key_event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : key_event_queue
//  Purpose  : Turns debounced key levels into press / auto-repeat event codes
//             buffered in a small FIFO with a valid/ready pop interface.
//  Revision : 1.0  initial release
// ============================================================================
module key_event_queue #(
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 400,
    parameter int REPEAT_RATE  = 120,
    parameter int CW           = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick_1ms,
    input  logic [4:0]               key_level,
    output logic                     evt_valid,
    output logic [2:0]               evt_code,
    input  logic                     evt_ready,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [CNTW-1:0] c_DEPTH    = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] c_CNT_ONE  = CNTW'(1);
    localparam logic [AW-1:0]   c_PTR_ONE  = AW'(1);
    localparam logic [CW-1:0]   c_DELAY    = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0]   c_RELOAD   = CW'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [CW-1:0]   c_HOLD_ONE = CW'(1);

    logic [4:0]      r_key_prev;
    logic [4:0]      r_pend;
    logic [2:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic            r_ovf;

    logic [3:0]      w_rep;
    logic [4:0]      w_rise;
    logic [4:0]      w_ev;
    logic [4:0]      w_push_oh;
    logic [4:0]      w_pend_nxt;
    logic [2:0]      w_push_code;
    logic            w_valid;
    logic            w_pop;
    logic            w_room;
    logic            w_push;
    logic            w_coalesce;

    // Per-direction hold counter; reloading below the threshold spaces later
    // repeats by REPEAT_RATE ticks after the first one at REPEAT_DELAY.
    for (genvar gi = 0; gi < 4; gi++) begin : g_repeat
        logic [CW-1:0] r_hold_cnt;
        logic [CW-1:0] w_hold_inc;

        assign w_hold_inc = r_hold_cnt + c_HOLD_ONE;
        assign w_rep[gi]  = key_level[gi] & tick_1ms & (w_hold_inc == c_DELAY);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hold_cnt <= '0;
            end else if (!key_level[gi]) begin
                r_hold_cnt <= '0;
            end else if (tick_1ms) begin
                r_hold_cnt <= w_rep[gi] ? c_RELOAD : w_hold_inc;
            end
        end
    end

    assign w_rise  = key_level & ~r_key_prev;
    assign w_ev    = w_rise | {1'b0, w_rep};
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & evt_ready;
    assign w_room  = (r_count < c_DEPTH) | w_pop;
    assign w_push  = (r_pend != 5'd0) & w_room;

    always_comb begin
        w_push_code = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_push_code = 3'(i);
            end
        end
    end

    // A bit leaving for the FIFO this cycle can absorb a fresh event without loss.
    always_comb begin
        w_push_oh  = w_push ? (5'b00001 << w_push_code) : 5'b00000;
        w_coalesce = |(w_ev & r_pend & ~w_push_oh);
        w_pend_nxt = w_ev | (r_pend & ~w_push_oh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_prev <= '0;
            r_pend     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 3'd0;
            end
        end else begin
            r_key_prev <= key_level;
            r_pend     <= w_pend_nxt;
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_code;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
            if (w_coalesce) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign evt_valid = w_valid;
    assign evt_code  = w_valid ? r_mem[r_rd_ptr] : 3'd0;
    assign evt_count = r_count;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_key_event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_event_queue
//  Purpose  : Directed and random stimulus for key_event_queue, compared every
//             cycle against a queue-based behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_key_event_queue;

    localparam int DEPTH = 4;
    localparam int RD    = 400;
    localparam int RR    = 120;
    localparam int CW    = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1ms;
    logic [4:0] key_level;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ready;
    logic [2:0] evt_count;
    logic       ovf;
    logic       ovf_clr;

    key_event_queue #(
        .DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CW(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1ms  (tick_1ms),
        .key_level (key_level),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .evt_count (evt_count),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model state: held-tick totals per key, pending flags, event queue.
    bit [4:0] m_prev;
    bit [4:0] m_pend;
    int       m_held [4];
    int       m_q [$];
    bit       m_ovf;
    int       pops [$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_prev = '0;
        m_pend = '0;
        for (int i = 0; i < 4; i++) m_held[i] = 0;
        m_q.delete();
        m_ovf = 1'b0;
    endfunction

    function automatic void model_step(input bit [4:0] lv, input bit rdy, input bit clr, input bit tk);
        bit [4:0] ev;
        bit       pop;
        bit       room;
        bit       coal;
        int       sel;
        ev = lv & ~m_prev;
        for (int i = 0; i < 4; i++) begin
            if (!lv[i]) begin
                m_held[i] = 0;
            end else if (tk) begin
                m_held[i]++;
                if (m_held[i] >= RD && ((m_held[i] - RD) % RR) == 0) ev[i] = 1'b1;
            end
        end
        pop  = (m_q.size() > 0) && rdy;
        room = (m_q.size() < DEPTH) || pop;
        sel  = -1;
        for (int i = 4; i >= 0; i--) if (m_pend[i]) sel = i;
        if (!room) sel = -1;
        coal = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == sel) begin
                m_pend[i] = ev[i];
            end else if (ev[i]) begin
                if (m_pend[i]) coal = 1'b1;
                m_pend[i] = 1'b1;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (sel >= 0) m_q.push_back(sel);
        if (coal) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_prev = lv;
    endfunction

    task automatic compare_outputs();
        chk("valid", int'(evt_valid), (m_q.size() != 0) ? 1 : 0);
        chk("count", int'(evt_count), m_q.size());
        chk("code",  int'(evt_code),  (m_q.size() != 0) ? m_q[0] : 0);
        chk("ovf",   int'(ovf),       int'(m_ovf));
    endtask

    // One clock: drive, record any DUT pop, advance model, check after the edge.
    task automatic step(input logic [4:0] lv, input logic rdy, input logic clr);
        bit tk;
        tk        = ((cyc % 4) == 3);
        key_level = lv;
        evt_ready = rdy;
        ovf_clr   = clr;
        tick_1ms  = tk;
        #1;
        if (evt_valid && evt_ready) pops.push_back(int'(evt_code));
        model_step(lv, rdy, clr, tk);
        @(posedge clk);
        #1;
        cyc++;
        compare_outputs();
    endtask

    task automatic do_reset();
        key_level = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick_1ms  = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_count", int'(evt_count), 0);
        chk("rst_code",  int'(evt_code),  0);
        chk("rst_ovf",   int'(ovf),       0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int count_code(input int code);
        int n;
        n = 0;
        foreach (pops[i]) if (pops[i] == code) n++;
        return n;
    endfunction

    initial begin
        logic [4:0] lv;
        rst_n     = 1'b1;
        key_level = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick_1ms  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single tap of up
        pops.delete();
        repeat (3) step(5'b00001, 1'b1, 1'b0);
        repeat (4) step(5'b00000, 1'b1, 1'b0);
        chk("tap_events", pops.size(), 1);
        chk("tap_code", (pops.size() > 0) ? pops[0] : -1, 0);
        chk("tap_ovf", int'(ovf), 0);

        // Simultaneous up, left, bomb
        pops.delete();
        step(5'b10101, 1'b0, 1'b0);
        repeat (4) step(5'b00000, 1'b0, 1'b0);
        chk("multi_count", int'(evt_count), 3);
        repeat (5) step(5'b00000, 1'b1, 1'b0);
        chk("multi_npop", pops.size(), 3);
        chk("multi_pop0", (pops.size() > 0) ? pops[0] : -1, 0);
        chk("multi_pop1", (pops.size() > 1) ? pops[1] : -1, 2);
        chk("multi_pop2", (pops.size() > 2) ? pops[2] : -1, 4);

        // Hold right for 700 ticks, then release and re-press
        pops.delete();
        repeat (2800) step(5'b01000, 1'b1, 1'b0);
        repeat (3) step(5'b00000, 1'b1, 1'b0);
        chk("hold_events", pops.size(), 4);
        chk("hold_code3", count_code(3), 4);
        repeat (2) step(5'b01000, 1'b1, 1'b0);
        repeat (3) step(5'b00000, 1'b1, 1'b0);
        chk("repress_events", pops.size(), 5);

        // Six down presses into a full FIFO
        for (int k = 0; k < 6; k++) begin
            step(5'b00010, 1'b0, 1'b0);
            step(5'b00000, 1'b0, 1'b0);
        end
        chk("full_count", int'(evt_count), 4);
        chk("full_ovf", int'(ovf), 1);
        step(5'b00000, 1'b1, 1'b0);
        chk("refill_count", int'(evt_count), 4);
        step(5'b00000, 1'b0, 1'b1);
        chk("ovf_cleared", int'(ovf), 0);

        // Pending bomb enters while the head leaves
        step(5'b10000, 1'b0, 1'b0);
        step(5'b10000, 1'b1, 1'b0);
        chk("pushpop_count", int'(evt_count), 4);
        chk("pushpop_ovf", int'(ovf), 0);
        repeat (6) step(5'b00000, 1'b1, 1'b0);
        chk("drained", int'(evt_count), 0);

        // Reset with queued and pending events
        step(5'b10101, 1'b0, 1'b0);
        repeat (3) step(5'b00000, 1'b0, 1'b0);
        step(5'b00010, 1'b0, 1'b0);
        chk("pre_rst_count", int'(evt_count), 3);
        do_reset();
        pops.delete();
        repeat (6) step(5'b00000, 1'b1, 1'b0);
        chk("no_stale", pops.size(), 0);

        // Random traffic
        lv = '0;
        repeat (3000) begin
            for (int b = 0; b < 5; b++) begin
                if ($urandom_range(15) == 0) lv[b] = ~lv[b];
            end
            step(lv, 1'($urandom_range(1)), ($urandom_range(31) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_event_queue.md
Name: key_event_queue

Overview:
- Consumer side of the push-button debouncers. It takes the debounced key levels and turns each press into a discrete event code.
- Direction keys that stay held generate auto-repeat events.
- Events are buffered in a small FIFO. Game logic pops them with a valid/ready handshake, so it never misses a press while busy.
- Sits between the per-key debouncers and the player-movement / bomb-placement FSM.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- REPEAT_DELAY, 400: held time in ms before the first auto-repeat; must satisfy REPEAT_DELAY > REPEAT_RATE.
- REPEAT_RATE, 120: ms between subsequent auto-repeats.
- CW, 10: hold-counter width; must satisfy 2^CW > REPEAT_DELAY.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- tick_1ms, input, 1: one-cycle strobe, once per ms.
- key_level, input, 5: debounced levels, bit order {bomb, right, left, down, up}; active high.
- evt_valid, output, 1: FIFO head holds an event.
- evt_code, output, 3: head event code: 0 up, 1 down, 2 left, 3 right, 4 bomb.
- evt_ready, input, 1: consumer accepts the head this cycle.
- evt_count, output, $clog2(DEPTH)+1: current FIFO occupancy.
- ovf, output, 1: sticky flag, set when an event is lost.
- ovf_clr, input, 1: clears ovf.

Behaviour:
- Reset (rst_n low, asynchronous), all state zero:
  - key_prev, pend[4:0], the four hold counters, FIFO pointers, evt_count, ovf.
  - evt_valid=0, evt_code=0.
  - rst_n low mid-operation discards all queued and pending events immediately.
- Edge detect:
  - rise[i] = key_level[i] & ~key_prev[i].
  - key_prev <= key_level every cycle.
- Auto-repeat, direction keys 0..3 only (bomb never repeats):
  - While key_level[i]=0: hold_cnt[i] <= 0.
  - While key_level[i]=1 and tick_1ms=1: hold_cnt[i] increments.
  - When the increment would reach REPEAT_DELAY: fire rep[i] for one cycle and load hold_cnt[i] <= REPEAT_DELAY-REPEAT_RATE.
  - First repeat arrives REPEAT_DELAY ticks after the press; each later one every REPEAT_RATE ticks.
- Pending register:
  - ev[i] = rise[i] | rep[i].
  - If ev[i] and pend[i] is already 1 and not being pushed this cycle: the event is coalesced and ovf <= 1.
  - Otherwise pend[i] <= 1.
- Push:
  - Each cycle, the lowest-index set pend bit is written to the FIFO when there is room; its pend bit clears.
  - Room means evt_count < DEPTH, or a pop occurs in the same cycle.
  - One push per cycle maximum. Simultaneous presses enter in code order (up first) on consecutive cycles.
  - A bit being pushed that also sees a new ev in the same cycle stays set (new event retained, no ovf).
- Pop and output:
  - evt_valid = (evt_count != 0).
  - evt_code = head entry when valid, 0 when empty.
  - Pop when evt_valid & evt_ready; evt_ready while empty is ignored.
  - Push and pop in the same cycle leaves evt_count unchanged.
  - Pointers wrap modulo DEPTH.
- Full FIFO: pend bits hold and wait; no loss unless a coalesce occurs.
- Latency:
  - key_level rises before edge n.
  - pend set at edge n.
  - FIFO written at edge n+1.
  - evt_valid=1 during cycle after n+1.
- ovf:
  - Set per the coalesce rule above.
  - ovf_clr=1 clears it.
  - A set condition in the same cycle as ovf_clr wins (ovf stays 1).

Test Plan:
- Reset, tap up for 3 cycles with evt_ready=1 -> exactly one event, code 0, evt_valid high 1 cycle, evt_count returns 0, ovf=0.
- Rise on up, left and bomb in the same cycle, evt_ready=0 -> codes 0,2,4 queued on consecutive cycles, evt_count=3; then ready=1 -> popped in order 0,2,4.
- Hold right for 700 ticks, REPEAT_DELAY=400, REPEAT_RATE=120 -> events at press and at ticks 400, 520, 640: 4 events total of code 3; release resets the count, and a new press yields an immediate event.
- DEPTH=4, ready=0, six distinct presses of down -> 4 entries, 5th held in pend, 6th coalesced and ovf=1; one pop -> pend pushed, count back at 4; ovf_clr -> ovf=0.
- FIFO full with ready=1 and a new bomb rise in the same cycle -> push and pop together, count stays 4, no ovf.
- rst_n low mid-stream with 3 entries queued and pend nonzero -> evt_valid=0 and evt_count=0 immediately; no stale events after release.
